instr_fetch: RTL

- Instruction fetch stage for the RISC-V core.
- Owns the program counter and issues one word-aligned read at a time to instruction memory over a valid/ready request channel.
- Registers the returned 32-bit instruction and its PC, then holds them valid until the decode and immediate-generation stage accepts.
- Supports a redirect input from branch/jump resolution, which discards any in-flight or held instruction.

---
 rtl/core_pkg.sv | 18 +
 rtl/pc_reg.sv | 27 ++
 rtl/instr_fetch.sv | 110 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, NOP encoding and PC constants.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset, load (redirect) over increment over hold, single cycle.
// Always word aligned; no backpressure of its own, the fetch FSM decides when it moves.
module pc_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= word_align(RESET_PC);
    end else if (load) begin
      pc <= word_align(load_pc);
    end else if (inc) begin
      // Natural 32-bit wrap: 32'hFFFF_FFFC steps to 0.
      pc <= word_align(pc + PC_STEP);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem read, 3-cycle minimum per instruction.
// Holds instr_out/instr_pc until instr_ready; redirect flushes in-flight or held work.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN_P   = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  fetch_state_t    state, state_nxt;
  logic            drop, drop_nxt;
  logic            pc_load, pc_inc, capture;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr_out_q, instr_pc_q;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      drop        <= 1'b0;
      instr_out_q <= NOP_INSTR;
      instr_pc_q  <= word_align(RESET_PC);
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (capture) begin
        instr_out_q <= imem_rsp_data;
        instr_pc_q  <= pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
        end else if (imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid && imem_rsp_valid) begin
          pc_load   = 1'b1;
          drop_nxt  = 1'b0;
          state_nxt = S_REQ;
        end else if (redirect_valid) begin
          // Response still owed for the old PC; mark it for discard.
          pc_load  = 1'b1;
          drop_nxt = 1'b1;
        end else if (imem_rsp_valid && drop) begin
          drop_nxt  = 1'b0;
          state_nxt = S_REQ;
        end else if (imem_rsp_valid) begin
          capture   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_load   = 1'b1;
          state_nxt = S_REQ;
        end else if (instr_ready) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
        drop_nxt  = 1'b0;
      end
    endcase
  end

  assign imem_req_valid = (state == S_REQ) && !redirect_valid && !rst;
  assign imem_req_addr  = pc;
  assign instr_valid    = (state == S_HOLD);
  assign instr_out      = instr_out_q;
  assign instr_pc       = instr_pc_q;

endmodule
